// File: rtl/instr_mem_ctrl_pkg.sv
// Shared definitions for the instruction-memory controller: FSM state encoding
// and the word returned for fetches outside the loaded program.
package instr_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/instr_mem_ctrl_sp_ram.sv
// Single-port program RAM: synchronous write, registered read with read enable
// so the output word holds between fetches.
module sp_ram #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // NOTE: the array itself is never reset; only the output register is, so the
   // storage maps onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction-memory responder: loads a program word-serially, then serves
// 1-cycle-latency fetches and stalls the pipeline while no program is resident.
module instr_mem_ctrl
   import instr_mem_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 2**ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] im_addr_i,
   input  logic                  im_rd_i,
   output logic [DATA_WIDTH-1:0] im_rdata_o,
   output logic                  im_rvalid_o,
   output logic                  im_stall_o,
   input  logic                  load_start_i,
   input  logic [ADDR_WIDTH:0]   load_len_i,
   input  logic                  load_valid_i,
   input  logic [DATA_WIDTH-1:0] load_data_i,
   output logic                  load_ready_o,
   output logic                  load_done_o
);

   localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(DEPTH);

   state_t                state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH:0]   len;
   logic [ADDR_WIDTH:0]   prog_len;
   logic                  start_ok;
   logic                  rd_accept;
   logic                  wr_beat;
   logic                  last_beat;
   logic                  oor_q;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign start_ok  = load_start_i && (load_len_i != '0) && (load_len_i <= MAX_LEN);
   assign rd_accept = im_rd_i && (state == RUN);
   assign wr_beat   = load_valid_i && (state == LOAD);
   assign last_beat = wr_beat && ({1'b0, wr_ptr} == len - 1'b1);
   assign ram_addr  = (state == LOAD) ? wr_ptr : im_addr_i;

   sp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_beat),
      .re    (rd_accept),
      .addr  (ram_addr),
      .wdata (load_data_i),
      .rdata (ram_rdata)
   );

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         len          <= '0;
         prog_len     <= '0;
         im_stall_o   <= 1'b1;
         load_ready_o <= 1'b0;
         load_done_o  <= 1'b0;
      end else begin
         load_done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  state        <= LOAD;
                  len          <= load_len_i;
                  wr_ptr       <= '0;
                  load_ready_o <= 1'b1;
               end
            end
            LOAD: begin
               if (wr_beat) begin
                  // A full-depth load wraps wr_ptr to 0 here, after the FSM has left LOAD.
                  wr_ptr <= wr_ptr + 1'b1;
                  if (last_beat) begin
                     state        <= RUN;
                     prog_len     <= len;
                     load_done_o  <= 1'b1;
                     load_ready_o <= 1'b0;
                     im_stall_o   <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (start_ok) begin
                  state        <= LOAD;
                  len          <= load_len_i;
                  wr_ptr       <= '0;
                  prog_len     <= '0;
                  load_ready_o <= 1'b1;
                  im_stall_o   <= 1'b1;
               end
            end
            default: begin
               state        <= IDLE;
               im_stall_o   <= 1'b1;
               load_ready_o <= 1'b0;
            end
         endcase
      end
   end

   // The range compare is captured with the read so it uses the prog_len in force at acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         im_rvalid_o <= 1'b0;
         oor_q       <= 1'b0;
      end else begin
         im_rvalid_o <= rd_accept;
         if (rd_accept) oor_q <= ({1'b0, im_addr_i} >= prog_len);
      end
   end

   assign im_rdata_o = oor_q ? DATA_WIDTH'(NOP_WORD) : ram_rdata;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: fetch expectations are queued at issue
// and checked by an independent monitor whenever im_rvalid_o is seen.
module tb_instr_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  im_addr_i = '0;
   logic        im_rd_i = 1'b0;
   logic [15:0] im_rdata_o;
   logic        im_rvalid_o;
   logic        im_stall_o;
   logic        load_start_i = 1'b0;
   logic [8:0]  load_len_i = '0;
   logic        load_valid_i = 1'b0;
   logic [15:0] load_data_i = '0;
   logic        load_ready_o;
   logic        load_done_o;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_q [$];

   instr_mem_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .im_addr_i    (im_addr_i),
      .im_rd_i      (im_rd_i),
      .im_rdata_o   (im_rdata_o),
      .im_rvalid_o  (im_rvalid_o),
      .im_stall_o   (im_stall_o),
      .load_start_i (load_start_i),
      .load_len_i   (load_len_i),
      .load_valid_i (load_valid_i),
      .load_data_i  (load_data_i),
      .load_ready_o (load_ready_o),
      .load_done_o  (load_done_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [8:0] len, input logic exp_ready);
      load_start_i = 1'b1;
      load_len_i   = len;
      step();
      load_start_i = 1'b0;
      check("load_ready_after_start", load_ready_o, exp_ready);
   endtask

   task automatic send_word(input logic [15:0] data, input logic last);
      load_valid_i = 1'b1;
      load_data_i  = data;
      step();
      load_valid_i = 1'b0;
      check("load_done", load_done_o, last);
      if (last) begin
         check("stall_after_done", im_stall_o, 1'b0);
         check("ready_after_done", load_ready_o, 1'b0);
      end
   endtask

   task automatic idle_beat();
      load_valid_i = 1'b0;
      step();
      check("load_done_gap", load_done_o, 1'b0);
   endtask

   task automatic issue_read(input logic [7:0] addr, input logic [15:0] exp);
      im_rd_i   = 1'b1;
      im_addr_i = addr;
      exp_q.push_back(exp);
      step();
      check("rvalid_latency", im_rvalid_o, 1'b1);
   endtask

   // Monitor: pops an expectation each cycle the DUT presents a fetched word.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && im_rvalid_o === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_rvalid", im_rvalid_o, 1'b0);
            else check("rdata", im_rdata_o, exp_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) step();
      rst = 1'b0;
      check("rst_stall", im_stall_o, 1'b1);
      check("rst_rvalid", im_rvalid_o, 1'b0);
      check("rst_ready", load_ready_o, 1'b0);
      check("rst_done", load_done_o, 1'b0);
      check("rst_rdata", im_rdata_o, 16'h0000);

      // Reads in IDLE are ignored
      im_rd_i   = 1'b1;
      im_addr_i = 8'd5;
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_stall", im_stall_o, 1'b1);
         check("idle_rvalid", im_rvalid_o, 1'b0);
         check("idle_ready", load_ready_o, 1'b0);
         check("idle_rdata", im_rdata_o, 16'h0000);
      end
      im_rd_i = 1'b0;

      // Load four words with a gap after the second
      start_load(9'd4, 1'b1);
      check("load_stall", im_stall_o, 1'b1);
      send_word(16'h1111, 1'b0);
      send_word(16'h2222, 1'b0);
      idle_beat();
      send_word(16'h3333, 1'b0);
      send_word(16'h4444, 1'b1);

      // Back-to-back reads, then hold, then out-of-range
      issue_read(8'd0, 16'h1111);
      issue_read(8'd1, 16'h2222);
      issue_read(8'd2, 16'h3333);
      issue_read(8'd3, 16'h4444);
      im_rd_i = 1'b0;
      step();
      check("hold_rvalid", im_rvalid_o, 1'b0);
      check("hold_rdata", im_rdata_o, 16'h4444);
      check("done_single_pulse", load_done_o, 1'b0);
      issue_read(8'd4, 16'h0000);
      im_rd_i = 1'b0;
      step();

      // Reload while a read is in flight
      im_rd_i      = 1'b1;
      im_addr_i    = 8'd1;
      exp_q.push_back(16'h2222);
      load_start_i = 1'b1;
      load_len_i   = 9'd2;
      step();
      load_start_i = 1'b0;
      check("inflight_rvalid", im_rvalid_o, 1'b1);
      check("reload_stall", im_stall_o, 1'b1);
      check("reload_ready", load_ready_o, 1'b1);
      im_addr_i = 8'd0;
      send_word(16'hAAAA, 1'b0);
      im_rd_i = 1'b0;
      send_word(16'hBBBB, 1'b1);
      issue_read(8'd0, 16'hAAAA);
      issue_read(8'd1, 16'hBBBB);
      issue_read(8'd2, 16'h0000);
      im_rd_i = 1'b0;
      step();

      // Length 0 while running is ignored
      start_load(9'd0, 1'b0);
      check("run_len0_stall", im_stall_o, 1'b0);

      // Reset after 3 of 5 beats
      start_load(9'd5, 1'b1);
      send_word(16'hC001, 1'b0);
      send_word(16'hC002, 1'b0);
      send_word(16'hC003, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_stall", im_stall_o, 1'b1);
      check("midrst_ready", load_ready_o, 1'b0);
      check("midrst_done", load_done_o, 1'b0);
      im_rd_i = 1'b1;
      step();
      check("midrst_read_ignored", im_rvalid_o, 1'b0);
      im_rd_i = 1'b0;
      start_load(9'd1, 1'b1);
      send_word(16'h5555, 1'b1);
      issue_read(8'd0, 16'h5555);
      issue_read(8'd1, 16'h0000);
      im_rd_i = 1'b0;
      step();

      // Invalid lengths ignored in IDLE
      rst = 1'b1;
      step();
      rst = 1'b0;
      start_load(9'd0, 1'b0);
      check("len0_stall", im_stall_o, 1'b1);
      start_load(9'd300, 1'b0);
      check("len300_stall", im_stall_o, 1'b1);

      // Full-depth load
      start_load(9'd256, 1'b1);
      for (int i = 0; i < 256; i++) send_word(16'h8000 | 16'(i), i == 255);
      issue_read(8'd255, 16'h80FF);
      issue_read(8'd0, 16'h8000);
      issue_read(8'd128, 16'h8080);
      im_rd_i = 1'b0;
      repeat (3) step();

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
